aes_128_stream_loader: RTL and testbench
========================================

AES_128_STREAM_LOADER -- requirements
Module: aes_128_stream_loader

Interface
REQ-001 The block SHALL have parameter LATENCY, default 21: cycles from an issue pulse to valid core output; it SHALL match the aes_128 core pipeline depth.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream word valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-006 The block SHALL have port in_data, input, 32 bits: key/state word.
REQ-007 The block SHALL have port key_hold, input, 1 bit: sampled on the last state word; 1 means the next block reuses the current key.
REQ-008 The block SHALL have port core_state, output, 128 bits: registered state to aes_128.state.
REQ-009 The block SHALL have port core_key, output, 128 bits: registered key to aes_128.key.
REQ-010 The block SHALL have port core_out, input, 128 bits: from aes_128.out.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse; out_data holds a finished ciphertext.
REQ-012 The block SHALL have port out_data, output, 128 bits: ciphertext, registered.
REQ-013 The block SHALL have port busy, output, 1 bit: a block is partially loaded or in flight.

Function
REQ-014 A word SHALL transfer only in a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles stall the word counter without loss.
REQ-015 The FSM SHALL have states LOAD_KEY (word count 0..3), LOAD_STATE (word count 0..3) and ISSUE.
REQ-016 In LOAD_KEY and LOAD_STATE, words SHALL arrive most-significant first; word k fills bits [127-32k -: 32] of a shadow register.
REQ-017 LOAD_KEY SHALL go to LOAD_STATE after its 4th transfer.
REQ-018 LOAD_STATE SHALL go to ISSUE after its 4th transfer; key_hold is captured with that 4th word.
REQ-019 ISSUE SHALL last exactly one cycle with in_ready=0.
REQ-020 In ISSUE, core_state and core_key SHALL update from the shadow registers, and an issue bit SHALL enter a LATENCY-deep shift register.
REQ-021 From ISSUE, the FSM SHALL go to LOAD_STATE if the captured key_hold=1 and a key has been loaded since reset; otherwise it SHALL go to LOAD_KEY.
REQ-022 If key_hold=1 is captured but no key has been loaded since reset, the block SHALL treat it as key_hold=0.
REQ-023 in_ready SHALL be 1 in LOAD_KEY and LOAD_STATE and 0 in ISSUE and while rst=1.
REQ-024 core_state and core_key SHALL be stable between ISSUE cycles; partial loads SHALL never be visible on them.
REQ-025 An issue in cycle N SHALL give out_valid=1 in cycle N+LATENCY+1, with out_data = the core_out value sampled at the end of cycle N+LATENCY.
REQ-026 out_data SHALL hold its value until the next out_valid.
REQ-027 Since issues are spaced at least 5 cycles apart (4 words + ISSUE), results SHALL emerge in issue order with no collisions; no output backpressure exists.
REQ-028 An in-flight counter (5 bits) SHALL increment on ISSUE and decrement on out_valid; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-029 busy SHALL equal (FSM not at word 0 of LOAD_KEY/LOAD_STATE) OR (in-flight counter != 0).

Reset
REQ-030 On rst=1 at a clock edge, the FSM SHALL go to LOAD_KEY with word count 0 and the key-loaded flag SHALL clear.
REQ-031 On rst=1 at a clock edge, the shadow registers, core_state, core_key and out_data SHALL clear to 0.
REQ-032 On rst=1 at a clock edge, the issue shift register and in-flight counter SHALL clear, and out_valid and busy SHALL be 0.
REQ-033 Reset mid-load or mid-flight SHALL discard all partial and pending blocks; no out_valid SHALL follow for them.

Verification
REQ-034 The bench SHALL cover this case: key words 2b7e1516,28aed2a6,abf71588,09cf4f3c, then state words 3243f6a8,885a308d,313198a2,e0370734, all back-to-back -> ISSUE 8 cycles after the first transfer, core_key=2b7e1516_28aed2a6_abf71588_09cf4f3c, then out_valid at ISSUE+LATENCY+1 with out_data=3925841d_02dc09fb_dc118597_196a0b32.
REQ-035 The bench SHALL cover this case: key 00010203..0c0d0e0f, state 00112233..ccddeeff -> out_data=69c4e0d8_6a7b0430_d8cdb780_70b4c55a.
REQ-036 The bench SHALL cover this case: block one as in REQ-034 with key_hold=1, block two as the same 4 state words only -> two out_valid pulses 5 cycles apart, both 3925841d_02dc09fb_dc118597_196a0b32, and core_key unchanged.
REQ-037 The bench SHALL cover this case: key_hold=1 on the very first block after reset -> the next block still expects 4 key words.
REQ-038 The bench SHALL cover this case: random in_valid gaps during REQ-034 -> same result, with ISSUE one cycle after the 8th accepted word.
REQ-039 The bench SHALL cover this case: rst after 2 key words, then a full REQ-035 load -> exactly one out_valid with 69c4e0d8_6a7b0430_d8cdb780_70b4c55a, and busy=0 afterward.

Source files
------------

// File: rtl/aes_128_stream_loader.sv
// aes_128_stream_loader
//
// Purpose:
//   Front end for a pipelined aes_128 core. It collects a 128-bit key and a
//   128-bit state from a 32-bit valid/ready word stream, most-significant word
//   first. It presents both to the core as registered values for one issue, and
//   returns the core result LATENCY cycles later as a registered one-cycle pulse.
//   A block may ask to keep the current key (key_hold on its last state word),
//   so that the next block sends only its four state words.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous, active-high reset
//   in_valid    upstream word valid
//   in_ready    word accepted this cycle (low in ISSUE and while rst=1)
//   in_data     32-bit key/state word
//   key_hold    sampled with the 4th state word: 1 = next block reuses the key
//   core_state  registered state to aes_128.state
//   core_key    registered key to aes_128.key
//   core_out    result from aes_128.out
//   out_valid   one-cycle pulse; out_data holds a finished ciphertext
//   out_data    registered ciphertext, held until the next out_valid
//   busy        a block is partially loaded or still in flight
//
// LATENCY must equal the core pipeline depth and be at least 2.

module aes_128_stream_loader #(
    parameter int LATENCY = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         key_hold,
    output logic [127:0] core_state,
    output logic [127:0] core_key,
    input  logic [127:0] core_out,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        LOAD_KEY   = 2'd0,
        LOAD_STATE = 2'd1,
        ISSUE      = 2'd2
    } fsm_t;

    fsm_t                fsm_q, fsm_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [127:0]        key_shadow_q, key_shadow_d;
    logic [127:0]        state_shadow_q, state_shadow_d;
    logic                hold_q, hold_d;
    logic                key_loaded_q, key_loaded_d;
    logic [127:0]        core_state_q, core_state_d;
    logic [127:0]        core_key_q, core_key_d;
    logic [LATENCY-1:0]  issue_sr_q, issue_sr_d;
    logic                out_valid_q, out_valid_d;
    logic [127:0]        out_data_q, out_data_d;
    logic [4:0]          inflight_q, inflight_d;

    logic                xfer;
    logic                issue;
    logic [6:0]          word_lsb;

    assign in_ready = !rst && (fsm_q != ISSUE);
    assign xfer     = in_valid && in_ready;

    // Word k lands in bits [127-32k -: 32]; (3-k)*32 is {~k, 5'b0} for a 2-bit k.
    assign word_lsb = {~cnt_q, 5'b0_0000};

    always_comb begin
        fsm_d          = fsm_q;
        cnt_d          = cnt_q;
        key_shadow_d   = key_shadow_q;
        state_shadow_d = state_shadow_q;
        hold_d         = hold_q;
        key_loaded_d   = key_loaded_q;
        core_state_d   = core_state_q;
        core_key_d     = core_key_q;
        issue          = 1'b0;

        case (fsm_q)
            LOAD_KEY: begin
                if (xfer) begin
                    key_shadow_d[word_lsb +: 32] = in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        fsm_d = LOAD_STATE;
                    end
                end
            end
            LOAD_STATE: begin
                if (xfer) begin
                    state_shadow_d[word_lsb +: 32] = in_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        hold_d = key_hold;
                        fsm_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_state_d = state_shadow_q;
                core_key_d   = key_shadow_q;
                issue        = 1'b1;
                // The flag is set by this issue but tested with its old value, so
                // a hold request on the first block after reset is ignored and the
                // next block must bring a key again.
                key_loaded_d = 1'b1;
                cnt_d        = 2'd0;
                fsm_d        = (hold_q && key_loaded_q) ? LOAD_STATE : LOAD_KEY;
            end
            default: begin
                fsm_d = LOAD_KEY;
                cnt_d = 2'd0;
            end
        endcase

        // Bit j is set in cycle N+1+j after an issue in cycle N, so the top bit
        // marks cycle N+LATENCY, when the core output belongs to that issue.
        issue_sr_d  = {issue_sr_q[LATENCY-2:0], issue};
        out_valid_d = issue_sr_q[LATENCY-1];
        out_data_d  = issue_sr_q[LATENCY-1] ? core_out : out_data_q;

        case ({issue, out_valid_q})
            2'b10:   inflight_d = inflight_q + 5'd1;
            2'b01:   inflight_d = inflight_q - 5'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= LOAD_KEY;
            cnt_q          <= 2'd0;
            key_shadow_q   <= '0;
            state_shadow_q <= '0;
            hold_q         <= 1'b0;
            key_loaded_q   <= 1'b0;
            core_state_q   <= '0;
            core_key_q     <= '0;
            issue_sr_q     <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            inflight_q     <= 5'd0;
        end else begin
            fsm_q          <= fsm_d;
            cnt_q          <= cnt_d;
            key_shadow_q   <= key_shadow_d;
            state_shadow_q <= state_shadow_d;
            hold_q         <= hold_d;
            key_loaded_q   <= key_loaded_d;
            core_state_q   <= core_state_d;
            core_key_q     <= core_key_d;
            issue_sr_q     <= issue_sr_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            inflight_q     <= inflight_d;
        end
    end

    assign core_state = core_state_q;
    assign core_key   = core_key_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = !((fsm_q != ISSUE) && (cnt_q == 2'd0)) || (inflight_q != 5'd0);

endmodule

// File: tb/tb_aes_128_stream_loader.sv
// Directed bench for aes_128_stream_loader. A behavioural stand-in for the
// aes_128 core returns the known FIPS-197 ciphertexts for the two reference
// key/state pairs (and a scrambled value otherwise) after the core latency.

module tb_aes_128_stream_loader;

    localparam int LATENCY = 21;

    localparam logic [127:0] K1 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] S1 = 128'h3243f6a8_885a308d_313198a2_e0370734;
    localparam logic [127:0] C1 = 128'h3925841d_02dc09fb_dc118597_196a0b32;
    localparam logic [127:0] K2 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] S2 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'h0;
    logic         key_hold = 1'b0;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ov_cnt = 0;
    int gap_max = 0;
    int first_xfer = 0;
    int last_xfer = 0;
    int issue_cyc = 0;

    aes_128_stream_loader #(.LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_hold   (key_hold),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;

    // Core stand-in: inputs seen in cycle M appear on core_out in cycle M+LATENCY-1,
    // i.e. an issue in cycle N (registers visible in N+1) shows up in N+LATENCY.
    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] s);
        if (k == K1 && s == S1) return C1;
        if (k == K2 && s == S2) return C2;
        return k ^ s ^ {4{32'hdeadbeef}};
    endfunction

    logic [127:0] pipe [0:LATENCY-2];
    always @(posedge clk) begin
        pipe[0] <= aes_ref(core_key, core_state);
        for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LATENCY-2];

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic put_word(input logic [31:0] w, input logic h);
        int guard;
        if (gap_max > 0) begin
            int g;
            g = int'($urandom_range(0, gap_max));
            in_valid = 1'b0;
            repeat (g) begin
                in_data  = $urandom;
                key_hold = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        key_hold = h;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("word_ready", guard < 10, 1);
        last_xfer = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // key is also the expected core_key after the issue when send_key=0.
    task automatic load_block(input logic [127:0] key, input logic send_key,
                              input logic [127:0] st, input logic hold);
        if (send_key) begin
            for (int k = 0; k < 4; k++) begin
                put_word(key[127-32*k -: 32], 1'b0);
                if (k == 0) first_xfer = last_xfer;
            end
        end
        for (int k = 0; k < 4; k++) begin
            put_word(st[127-32*k -: 32], (k == 3) ? hold : ~hold);
            if (k == 0 && !send_key) first_xfer = last_xfer;
        end
        chk("issue_ready_low", in_ready, 0);
        chk("issue_after_last_word", cyc - last_xfer, 1);
        issue_cyc = cyc;
        @(negedge clk);
        chk("core_key", core_key, key);
        chk("core_state", core_state, st);
        chk("busy_in_flight", busy, 1);
    endtask

    task automatic wait_out(input string tag, input logic [127:0] exp, input int exp_cyc);
        int guard = 0;
        while (out_valid !== 1'b1 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_cycle"}, cyc, exp_cyc);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        chk({tag, "_pulse"}, out_valid, 0);
        chk({tag, "_held"}, out_data, exp);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        key_hold = 1'b0;
        @(negedge clk);
        chk("rst_ready_low", in_ready, 0);
        @(negedge clk);
        chk("rst_ready_low2", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_state", core_state, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_busy", busy, 0);
    endtask

    initial begin
        int i1;
        int ov0;

        do_reset();

        // Back-to-back reference block.
        load_block(K1, 1'b1, S1, 1'b0);
        chk("ref1_issue_8_after_first", issue_cyc - first_xfer, 8);
        wait_out("ref1", C1, issue_cyc + LATENCY + 1);
        chk("ref1_busy_after", busy, 0);
        repeat (5) @(negedge clk);
        chk("ref1_data_kept", out_data, C1);

        // Second reference vector.
        load_block(K2, 1'b1, S2, 1'b0);
        wait_out("ref2", C2, issue_cyc + LATENCY + 1);

        // Random in_valid gaps with junk data on the bus.
        gap_max = 3;
        load_block(K1, 1'b1, S1, 1'b0);
        gap_max = 0;
        wait_out("gaps", C1, issue_cyc + LATENCY + 1);

        // key_hold: second block sends state words only.
        load_block(K1, 1'b1, S1, 1'b1);
        i1 = issue_cyc;
        load_block(K1, 1'b0, S1, 1'b0);
        chk("hold_issue_spacing", issue_cyc - i1, 5);
        wait_out("hold_a", C1, i1 + LATENCY + 1);
        wait_out("hold_b", C1, issue_cyc + LATENCY + 1);
        chk("hold_key_kept", core_key, K1);

        // key_hold on the first block after reset is ignored.
        do_reset();
        load_block(K1, 1'b1, S1, 1'b1);
        i1 = issue_cyc;
        load_block(K2, 1'b1, S2, 1'b0);
        chk("first_hold_issue_8_after_first", issue_cyc - first_xfer, 8);
        wait_out("first_hold_a", C1, i1 + LATENCY + 1);
        wait_out("first_hold_b", C2, issue_cyc + LATENCY + 1);

        // Reset after two key words, then a clean load.
        put_word(K2[127:96], 1'b0);
        put_word(K2[95:64], 1'b0);
        chk("partial_busy", busy, 1);
        do_reset();
        ov0 = ov_cnt;
        load_block(K2, 1'b1, S2, 1'b0);
        chk("after_partial_issue_8", issue_cyc - first_xfer, 8);
        wait_out("after_partial", C2, issue_cyc + LATENCY + 1);
        repeat (30) @(negedge clk);
        chk("after_partial_one_pulse", ov_cnt - ov0, 1);
        chk("after_partial_busy", busy, 0);

        // Reset while a block is in flight drops its result.
        load_block(K1, 1'b1, S1, 1'b0);
        repeat (5) @(negedge clk);
        do_reset();
        ov0 = ov_cnt;
        repeat (40) @(negedge clk);
        chk("flight_drop_no_pulse", ov_cnt - ov0, 0);
        chk("flight_drop_busy", busy, 0);
        chk("flight_drop_out_data", out_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
